img_writer: RTL and testbench
=============================

Name: img_writer

Overview:
- Avalon-MM slave that turns CPU-written pixels into a VGA-style RGB/HSYNC/VSYNC stream.
- It is the transmit-side counterpart of the frame-capture reader and uses the same pixel packing and active-low sync polarity.
- The CPU pushes pixels into an on-chip FIFO. A raster timing generator pops one pixel per active pixel slot.
- Intended for driving known frames into the capture path and for board-level video output.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, HSYNC pulse width in pixels
- H_BP, 48, horizontal back porch in pixels
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, VSYNC pulse width in lines
- V_BP, 33, vertical back porch in lines
- CLK_DIV, 2, clk cycles per pixel slot (1 or more)
- FIFO_DEPTH, 16, pixel FIFO entries (power of 2, 2 or more)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- writedata  in  32  Avalon write data
- write  in  1  Avalon write strobe
- chipselect  in  1  Avalon chip select
- address  in  8  Avalon word address
- read  in  1  Avalon read strobe
- readdata  out  32  Avalon read data
- VGA_R  out  8  red
- VGA_G  out  8  green
- VGA_B  out  8  blue
- HSYNC  out  1  horizontal sync, active low
- VSYNC  out  1  vertical sync, active low
- active  out  1  high while the current pixel slot is in the active region

Behaviour:
- Reset values:
  - VGA_R, VGA_G, VGA_B = 0; HSYNC = 1; VSYNC = 1; active = 0; readdata = 0.
  - FIFO empty; ctrl.enable = 0; sticky flags = 0; frame_count = 0.
  - Reset mid-frame aborts the frame immediately.
- Register writes (take effect when chipselect && write):
  - Addr 0 PIXEL: pushes writedata[31:8] as {R,G,B}; writedata[7:0] is ignored.
  - If the FIFO is full and no pop occurs in the same cycle, the pixel is dropped and sticky overflow is set. A push coinciding with a pop is always accepted.
  - Addr 1 CTRL: bit0 = enable. bit1 = clear sticky flags (self-clearing, applied in that cycle). Writing enable = 0 flushes the FIFO.
  - Other addresses: writes are ignored.
- Register reads (combinational, zero wait states, valid when chipselect && read):
  - Addr 0 STATUS:
    - [0] enable
    - [1] empty
    - [2] full
    - [3] overflow (sticky)
    - [4] underflow (sticky)
    - [5] in_vblank
    - [15:8] FIFO level
    - rest 0
  - Addr 1: frame_count (32 bits).
  - Other addresses: 0.
  - readdata is 0 whenever chipselect && read is false.
- Pixel tick:
  - A divider counts 0..CLK_DIV-1. tick is high when the divider is 0.
  - The divider runs only while state != IDLE.
- Counters:
  - hcount runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - vcount runs 0..V_TOTAL-1, defined analogously.
  - Both advance on tick. hcount wraps to 0 and increments vcount. vcount wraps to 0 at the end of the frame, and frame_count increments at that wrap (32-bit, wraps naturally).
- Region decode, per slot:
  - active: hcount < H_ACTIVE and vcount < V_ACTIVE.
  - HSYNC low: H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
  - VSYNC low: analogous on vcount.
  - in_vblank: vcount >= V_ACTIVE.
- FSM:
  - IDLE: outputs at reset values; counters held at 0. Goes to PRIME when enable = 1.
  - PRIME: waits until the FIFO level >= 1, or one full line time (H_TOTAL ticks) has elapsed, then goes to RUN with hcount = vcount = 0.
  - RUN: free-running raster. Goes to IDLE immediately when enable = 0 (counters cleared, FIFO flushed).
- Output pipeline:
  - Outputs are registered, so each pixel slot appears 1 clk after its tick.
  - Outputs hold for CLK_DIV clks.
- Active slot in RUN:
  - FIFO not empty: pop and output the popped pixel.
  - FIFO empty: output black and set sticky underflow. The raster never stalls.
- Blanking slots: RGB = 0 and no pop.
- A sticky-clear and a new error event in the same cycle: the flag ends set.

Decomposition:
- img_pkg holds:
  - Register address constants (ADDR_PIXEL = 0, ADDR_CTRL = 1).
  - STATUS bit-position constants.
  - The FSM state enum (IDLE, PRIME, RUN).
  - A function computing H_TOTAL/V_TOTAL.
- Sub-module pixel_fifo: synchronous FIFO with parameters WIDTH = 24 and DEPTH.
  - Ports: push, pop, din, dout, level, full, empty, flush.
  - Behaviour: first-word fall-through, with simultaneous push/pop allowed.

Test Plan:
All scenarios use H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1, CLK_DIV=2, FIFO_DEPTH=4.
1. Reset, then read addr 0 -> STATUS = 0x0000_0002 (empty only); HSYNC = VSYNC = 1; RGB = 0.
2. Push 0x112233_00, 0x445566_00, then write CTRL = 1 -> first active slot RGB = 11/22/33, next = 44/55/66. Subsequent active slots are 0 and underflow (STATUS[4]) = 1.
3. Keep the FIFO fed and enabled for 2 frames:
   - HSYNC is low for exactly 4 clks per line, starting 5 slots (10 clks) after line start.
   - VSYNC is low during vcount = 3.
   - frame_count reads 2.
4. Disabled, push 5 pixels -> level = 4, full = 1, overflow = 1. Write CTRL = 0x2 -> overflow = 0, level still 4.
5. Write CTRL = 0 mid-line in RUN -> the next clk shows HSYNC = VSYNC = 1 and RGB = 0, and STATUS reads level 0, empty.
6. Assert reset during an active pixel -> all outputs at reset values the next clk. Re-enabling restarts at hcount = vcount = 0.

Source files
------------

// File: rtl/img_pkg.sv
// Shared constants, state encoding and timing helpers for the image writer.
package img_pkg;

  localparam logic [7:0] ADDR_PIXEL  = 8'd0;
  localparam logic [7:0] ADDR_CTRL   = 8'd1;
  localparam logic [7:0] ADDR_STATUS = 8'd0;
  localparam logic [7:0] ADDR_FRAMES = 8'd1;

  localparam int ST_ENABLE    = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_FULL      = 2;
  localparam int ST_OVERFLOW  = 3;
  localparam int ST_UNDERFLOW = 4;
  localparam int ST_VBLANK    = 5;
  localparam int ST_LEVEL_LSB = 8;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_t;

  function automatic int line_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// First-word fall-through pixel FIFO; a push into a full FIFO is taken when a pop coincides.
module pixel_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/img_writer.sv
// Avalon-MM slave that plays CPU-written pixels out as an RGB/HSYNC/VSYNC raster.
module img_writer
  import img_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] writedata,
  input  logic        write,
  input  logic        chipselect,
  input  logic [7:0]  address,
  input  logic        read,
  output logic [31:0] readdata,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        active
);

  localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [HW-1:0] H_ACT_END    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [DW-1:0] DIV_LAST     = DW'(CLK_DIV - 1);

  state_t        state;
  logic [DW-1:0] div;
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic [HW-1:0] prime_cnt;
  logic [31:0]   frame_count;
  logic          ctrl_enable;
  logic          overflow;
  logic          underflow;

  logic          pixel_wr;
  logic          ctrl_wr;
  logic          disable_req;
  logic          flush;
  logic          tick;
  logic          run_tick;
  logic          in_active;
  logic          in_hsync;
  logic          in_vsync;
  logic          in_vblank;
  logic          pop;
  logic          overflow_evt;
  logic          underflow_evt;
  logic [23:0]   fifo_dout;
  logic [LW-1:0] fifo_level;
  logic          fifo_full;
  logic          fifo_empty;
  logic          unused_wdata;

  assign unused_wdata = ^writedata[7:2];

  assign pixel_wr    = chipselect && write && (address == ADDR_PIXEL);
  assign ctrl_wr     = chipselect && write && (address == ADDR_CTRL);
  assign disable_req = ctrl_wr && !writedata[0];
  // Only a running-to-stopped transition flushes, so pixels queued while idle survive a flag clear.
  assign flush       = disable_req && ctrl_enable;

  assign tick      = (div == '0) && (state != IDLE);
  assign run_tick  = (state == RUN) && tick && !disable_req;
  assign in_active = (hcount < H_ACT_END) && (vcount < V_ACT_END);
  assign in_hsync  = (hcount >= H_SYNC_START) && (hcount < H_SYNC_END);
  assign in_vsync  = (vcount >= V_SYNC_START) && (vcount < V_SYNC_END);
  assign in_vblank = (vcount >= V_ACT_END);

  assign pop           = run_tick && in_active && !fifo_empty;
  assign underflow_evt = run_tick && in_active && fifo_empty;
  assign overflow_evt  = pixel_wr && fifo_full && !pop;

  pixel_fifo #(
    .WIDTH (24),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (pixel_wr),
    .pop   (pop),
    .din   (writedata[31:8]),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A set event in the same cycle as a clear wins, so no error is ever lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_enable <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (ctrl_wr) ctrl_enable <= writedata[0];
      if (ctrl_wr && writedata[1]) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      if (overflow_evt)  overflow  <= 1'b1;
      if (underflow_evt) underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      div         <= '0;
      hcount      <= '0;
      vcount      <= '0;
      prime_cnt   <= '0;
      frame_count <= '0;
      {VGA_R, VGA_G, VGA_B} <= '0;
      HSYNC       <= 1'b1;
      VSYNC       <= 1'b1;
      active      <= 1'b0;
    end else begin
      div <= (state == IDLE || div == DIV_LAST) ? '0 : div + 1'b1;
      case (state)
        IDLE: begin
          hcount    <= '0;
          vcount    <= '0;
          prime_cnt <= '0;
          {VGA_R, VGA_G, VGA_B} <= '0;
          HSYNC     <= 1'b1;
          VSYNC     <= 1'b1;
          active    <= 1'b0;
          if (ctrl_enable && !disable_req) state <= PRIME;
        end
        PRIME: begin
          if (disable_req) begin
            state <= IDLE;
          end else if (!fifo_empty || (tick && prime_cnt == H_LAST)) begin
            state     <= RUN;
            div       <= '0;
            prime_cnt <= '0;
          end else if (tick) begin
            prime_cnt <= prime_cnt + 1'b1;
          end
        end
        RUN: begin
          if (disable_req) begin
            state  <= IDLE;
            div    <= '0;
            hcount <= '0;
            vcount <= '0;
            {VGA_R, VGA_G, VGA_B} <= '0;
            HSYNC  <= 1'b1;
            VSYNC  <= 1'b1;
            active <= 1'b0;
          end else if (tick) begin
            // Underflowed active slots go out black; the raster never waits for data.
            {VGA_R, VGA_G, VGA_B} <= pop ? fifo_dout : 24'h0;
            HSYNC  <= !in_hsync;
            VSYNC  <= !in_vsync;
            active <= in_active;
            if (hcount == H_LAST) begin
              hcount <= '0;
              if (vcount == V_LAST) begin
                vcount      <= '0;
                frame_count <= frame_count + 32'd1;
              end else begin
                vcount <= vcount + 1'b1;
              end
            end else begin
              hcount <= hcount + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    readdata = '0;
    if (chipselect && read) begin
      if (address == ADDR_STATUS) begin
        readdata[ST_ENABLE]    = ctrl_enable;
        readdata[ST_EMPTY]     = fifo_empty;
        readdata[ST_FULL]      = fifo_full;
        readdata[ST_OVERFLOW]  = overflow;
        readdata[ST_UNDERFLOW] = underflow;
        readdata[ST_VBLANK]    = in_vblank;
        readdata[ST_LEVEL_LSB +: 8] = 8'(fifo_level);
      end else if (address == ADDR_FRAMES) begin
        readdata = frame_count;
      end
    end
  end

endmodule

// File: tb/tb_img_writer.sv
// Directed self-checking bench for img_writer on a tiny 8x5-slot raster.
module tb_img_writer;

  logic        clk;
  logic        reset;
  logic [31:0] writedata;
  logic        write;
  logic        chipselect;
  logic [7:0]  address;
  logic        read;
  logic [31:0] readdata;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;
  logic        HSYNC;
  logic        VSYNC;
  logic        active;

  int tests_run;
  int tests_failed;

  logic        tr_h   [200];
  logic        tr_v   [200];
  logic        tr_a   [200];
  logic [23:0] tr_rgb [200];

  img_writer #(
    .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (2), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .CLK_DIV (2), .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .writedata  (writedata),
    .write      (write),
    .chipselect (chipselect),
    .address    (address),
    .read       (read),
    .readdata   (readdata),
    .VGA_R      (VGA_R),
    .VGA_G      (VGA_G),
    .VGA_B      (VGA_B),
    .HSYNC      (HSYNC),
    .VSYNC      (VSYNC),
    .active     (active)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] pix(input int n);
    return {8'(n + 1), 8'(n + 8'h41), 8'(8'hC0 - n)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] addr, input logic [31:0] data);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = addr;
    writedata  = data;
    step(1);
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] addr, output logic [31:0] data);
    chipselect = 1'b1;
    read       = 1'b1;
    address    = addr;
    #1;
    data       = readdata;
    chipselect = 1'b0;
    read       = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  task automatic wait_for_active();
    for (int i = 0; i < 200 && !active; i++) step(1);
    checkOutput("active_seen", {31'd0, active}, 32'd1);
  endtask

  initial begin
    logic [31:0] st;
    int pushed;
    int t0;
    int cnt;
    int first;
    int idx;

    clk = 1'b0; reset = 1'b1; writedata = '0; write = 1'b0;
    chipselect = 1'b0; address = '0; read = 1'b0;
    tests_run = 0; tests_failed = 0;

    // 1: reset state
    do_reset();
    bus_read(8'd0, st);
    checkOutput("reset_status", st, 32'h2);
    bus_read(8'd1, st);
    checkOutput("reset_frames", st, 32'h0);
    checkOutput("reset_sync", {30'd0, HSYNC, VSYNC}, 32'h3);
    checkOutput("reset_rgb", {VGA_R, VGA_G, VGA_B}, 32'h0);
    checkOutput("reset_active", {31'd0, active}, 32'h0);

    // 2: two pixels then underflow
    applyStimulus(8'd0, 32'h1122_3300);
    applyStimulus(8'd0, 32'h4455_6600);
    applyStimulus(8'd1, 32'h1);
    wait_for_active();
    checkOutput("px0", {VGA_R, VGA_G, VGA_B}, 32'h112233);
    step(1);
    checkOutput("px0_hold", {VGA_R, VGA_G, VGA_B}, 32'h112233);
    step(1);
    checkOutput("px1", {VGA_R, VGA_G, VGA_B}, 32'h445566);
    step(2);
    checkOutput("px2_black", {VGA_R, VGA_G, VGA_B}, 32'h0);
    checkOutput("px2_active", {31'd0, active}, 32'h1);
    bus_read(8'd0, st);
    checkOutput("underflow_status", st, 32'h13);

    // 3: fed raster for two frames
    do_reset();
    for (int i = 0; i < 4; i++) applyStimulus(8'd0, {pix(i), 8'h00});
    pushed = 4;
    applyStimulus(8'd1, 32'h1);
    for (int c = 0; c < 200; c++) begin
      tr_h[c] = HSYNC; tr_v[c] = VSYNC; tr_a[c] = active;
      tr_rgb[c] = {VGA_R, VGA_G, VGA_B};
      bus_read(8'd0, st);
      if (!st[2]) begin
        chipselect = 1'b1; write = 1'b1; address = 8'd0;
        writedata = {pix(pushed), 8'h00};
        pushed++;
      end
      step(1);
      chipselect = 1'b0; write = 1'b0;
    end
    bus_read(8'd1, st);
    checkOutput("frame_count", st, 32'd2);
    bus_read(8'd0, st);
    checkOutput("feed_flags", {30'd0, st[4:3]}, 32'h0);
    t0 = -1;
    for (int c = 0; c < 40; c++) if (t0 < 0 && tr_a[c]) t0 = c;
    checkOutput("trace_active", {31'd0, t0 >= 0}, 32'd1);
    if (t0 >= 0) begin
      for (int ln = 0; ln < 2; ln++) begin
        cnt = 0; first = -1;
        for (int c = t0 + 16*ln; c < t0 + 16*ln + 16; c++)
          if (!tr_h[c]) begin cnt++; if (first < 0) first = c - t0 - 16*ln; end
        checkOutput("hsync_width", cnt, 32'd4);
        checkOutput("hsync_offset", first, 32'd10);
      end
      cnt = 0; first = -1;
      for (int c = t0; c < t0 + 80; c++)
        if (!tr_v[c]) begin cnt++; if (first < 0) first = c - t0; end
      checkOutput("vsync_width", cnt, 32'd16);
      checkOutput("vsync_offset", first, 32'd48);
      for (int k = 0; k < 16; k++) begin
        idx = t0 + (k / 8) * 80 + ((k % 8) / 4) * 16 + (k % 4) * 2;
        checkOutput($sformatf("feed_px%0d", k), {7'd0, tr_a[idx], tr_rgb[idx]}, {8'h01, pix(k)});
      end
      cnt = 0;
      for (int c = t0; c < t0 + 160; c++) if (!tr_a[c] && tr_rgb[c] != 24'h0) cnt++;
      checkOutput("blank_rgb", cnt, 32'd0);
    end

    // 4: overflow while disabled, then clear
    do_reset();
    for (int i = 0; i < 5; i++) applyStimulus(8'd0, {pix(10 + i), 8'h00});
    bus_read(8'd0, st);
    checkOutput("overflow_status", st, 32'h40C);
    chipselect = 1'b0; read = 1'b1; address = 8'd0;
    #1;
    checkOutput("rd_no_cs", readdata, 32'h0);
    read = 1'b0;
    applyStimulus(8'd1, 32'h2);
    bus_read(8'd0, st);
    checkOutput("cleared_status", st, 32'h404);

    // 5: disable mid-line
    applyStimulus(8'd1, 32'h1);
    wait_for_active();
    checkOutput("t5_first_px", {VGA_R, VGA_G, VGA_B}, pix(10));
    applyStimulus(8'd1, 32'h0);
    checkOutput("dis_rgb", {VGA_R, VGA_G, VGA_B}, 32'h0);
    checkOutput("dis_sync", {30'd0, HSYNC, VSYNC}, 32'h3);
    checkOutput("dis_active", {31'd0, active}, 32'h0);
    bus_read(8'd0, st);
    checkOutput("dis_status", st, 32'h2);
    applyStimulus(8'd1, 32'h1);
    for (int i = 0; i < 200 && HSYNC; i++) step(1);
    checkOutput("hsync_seen", {31'd0, HSYNC}, 32'h0);
    applyStimulus(8'd1, 32'h0);
    checkOutput("dis_hsync", {30'd0, HSYNC, VSYNC}, 32'h3);
    bus_read(8'd0, st);
    checkOutput("dis2_status", st, 32'h12);

    // 6: reset during an active pixel, then restart
    do_reset();
    applyStimulus(8'd0, {pix(20), 8'h00});
    applyStimulus(8'd0, {pix(21), 8'h00});
    applyStimulus(8'd1, 32'h1);
    wait_for_active();
    checkOutput("t6_px", {VGA_R, VGA_G, VGA_B}, pix(20));
    reset = 1'b1;
    step(1);
    checkOutput("rst_rgb", {VGA_R, VGA_G, VGA_B}, 32'h0);
    checkOutput("rst_sync", {30'd0, HSYNC, VSYNC}, 32'h3);
    checkOutput("rst_active", {31'd0, active}, 32'h0);
    reset = 1'b0;
    bus_read(8'd0, st);
    checkOutput("rst_status", st, 32'h2);
    applyStimulus(8'd0, {pix(30), 8'h00});
    applyStimulus(8'd0, {pix(31), 8'h00});
    applyStimulus(8'd1, 32'h1);
    wait_for_active();
    checkOutput("restart_px", {VGA_R, VGA_G, VGA_B}, pix(30));
    cnt = 0;
    while (cnt < 40 && HSYNC) begin
      step(1);
      cnt++;
    end
    checkOutput("restart_hsync", cnt, 32'd10);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
